// File: rtl/trng_pkg.sv
// rtl/trng_pkg.sv - default constants and width helper for the TRNG word packer
package trng_pkg;

  localparam int TRNG_WORD_W     = 8;
  localparam int TRNG_FIFO_DEPTH = 4;
  localparam int TRNG_RCT_CUTOFF = 32;

  // Width of a counter that must be able to hold the value n itself.
  function automatic int trng_cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/trng_sync_fifo.sv
// rtl/trng_sync_fifo.sv - first-word-fall-through synchronous FIFO with flush
module trng_sync_fifo
  import trng_pkg::*;
#(
  parameter int W     = TRNG_WORD_W,
  parameter int DEPTH = TRNG_FIFO_DEPTH,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = trng_cnt_w(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic [W-1:0]  push_data,
  input  logic          pop,
  output logic [W-1:0]  pop_data,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign pop_data = mem_q[rd_ptr_q];

  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      unique case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/trng_word_packer.sv
// rtl/trng_word_packer.sv - packs debiased bits MSB-first into buffered words
// Optional repetition-count health test enabled by TRNG_REPETITION_TEST_EN.
module trng_word_packer
  import trng_pkg::*;
#(
  parameter int WORD_W     = TRNG_WORD_W,
  parameter int FIFO_DEPTH = TRNG_FIFO_DEPTH,
  parameter int RCT_CUTOFF = TRNG_RCT_CUTOFF,
  localparam int CW        = trng_cnt_w(FIFO_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_in,
  input  logic              bit_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_valid,
  output logic [CW-1:0]     fifo_count,
  output logic              overflow,
  output logic              health_fail
);

  localparam int BW = $clog2(WORD_W);

  logic [WORD_W-2:0] shift_q, shift_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic              overflow_q, overflow_d;
  logic [WORD_W-1:0] next_word;
  logic              accept, trip, halted;
  logic              fifo_push, fifo_pop, fifo_flush, fifo_full, fifo_empty;

`ifdef TRNG_REPETITION_TEST_EN
  localparam int RW = trng_cnt_w(RCT_CUTOFF);

  logic [RW-1:0] run_cnt_q, run_cnt_d;
  logic          last_bit_q, last_bit_d;
  logic          health_fail_q, health_fail_d;

  always_comb begin
    run_cnt_d     = run_cnt_q;
    last_bit_d    = last_bit_q;
    health_fail_d = health_fail_q;
    trip          = 1'b0;
    if (accept) begin
      last_bit_d = bit_in;
      if (run_cnt_q == '0 || bit_in != last_bit_q) begin
        run_cnt_d = RW'(1);
      end else if (run_cnt_q < RW'(RCT_CUTOFF)) begin
        run_cnt_d = run_cnt_q + RW'(1);
      end
      if (run_cnt_d == RW'(RCT_CUTOFF)) begin
        trip          = 1'b1;
        health_fail_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q     <= '0;
      last_bit_q    <= 1'b0;
      health_fail_q <= 1'b0;
    end else begin
      run_cnt_q     <= run_cnt_d;
      last_bit_q    <= last_bit_d;
      health_fail_q <= health_fail_d;
    end
  end

  assign halted      = health_fail_q;
  assign health_fail = health_fail_q;
`else
  assign trip        = 1'b0;
  assign halted      = 1'b0;
  assign health_fail = 1'b0;
`endif

  assign accept    = bit_valid && !halted;
  assign next_word = {shift_q, bit_in};
  assign fifo_pop  = word_ready && !fifo_empty;

  always_comb begin
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    overflow_d = overflow_q;
    fifo_push  = 1'b0;
    fifo_flush = 1'b0;
    if (accept) begin
      shift_d = next_word[WORD_W-2:0];
      if (bit_cnt_q == BW'(WORD_W - 1)) begin
        bit_cnt_d = '0;
        fifo_push = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + BW'(1);
      end
    end
    // A tripping bit discards everything, including a word it would complete.
    if (trip) begin
      shift_d    = '0;
      bit_cnt_d  = '0;
      fifo_push  = 1'b0;
      fifo_flush = 1'b1;
    end
    if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  trng_sync_fifo #(
    .W     (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (next_word),
    .pop       (fifo_pop),
    .pop_data  (word_data),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign word_valid = !fifo_empty;
  assign overflow   = overflow_q;

endmodule
